// File: rtl/convcor_param.sv
// Parametrised complex convolution / correlation engine.
// Loads N-sample complex sequences A and B, then streams mode-selected results with no back-pressure.
module convcor_param #(
    parameter int DW = 8,
    parameter int N  = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [2*DW-1:0]                  in_a,
    input  logic [2*DW-1:0]                  in_b,
    input  logic [1:0]                       in_mode,
    output logic                             out_valid,
    output logic [2*(2*DW+$clog2(N)+1)-1:0]  out
);
    localparam int OW = 2*DW + $clog2(N) + 1;
    localparam int CW = $clog2(N);
    localparam int XW = $clog2(2*N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [XW-1:0]          r_idx;
    logic [XW-1:0]          w_idx_nxt;
    logic [XW-1:0]          w_sel;
    logic [XW-1:0]          w_nres;
    logic [1:0]             r_mode;
    logic [1:0]             w_mode_nxt;
    logic                   w_wr_en;
    logic [CW-1:0]          w_wr_idx;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic [2*OW-1:0]        r_out;
    logic [2*OW-1:0]        w_out_nxt;
    logic signed [OW-1:0]   w_acc_re;
    logic signed [OW-1:0]   w_acc_im;

    logic signed [DW-1:0]   r_a_re [N];
    logic signed [DW-1:0]   r_a_im [N];
    logic signed [DW-1:0]   r_b_re [N];
    logic signed [DW-1:0]   r_b_im [N];

    // Full-precision complex product; truncation to OW is exact because OW covers the range.
    function automatic logic [2*OW-1:0] cmul(
        input logic signed [OW-1:0] ar,
        input logic signed [OW-1:0] ai,
        input logic signed [OW-1:0] br,
        input logic signed [OW-1:0] bi
    );
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    // Result count of the burst for the latched mode.
    always_comb begin
        case (r_mode)
            2'd0:    w_nres = XW'(2*N - 1);
            2'd1:    w_nres = XW'(1);
            2'd2:    w_nres = XW'(2*N - 1);
            2'd3:    w_nres = XW'(N);
            default: w_nres = XW'(1);
        endcase
    end

    // Result index: during the last load cycle result 0 is computed so it is registered on time.
    always_comb begin
        if (r_state == S_LOAD) begin
            w_sel = '0;
        end else begin
            w_sel = r_idx;
        end
    end

    // Accumulate one output sample; the last sample bypasses the buffer while it is still arriving.
    always_comb begin : result_calc
        int                   s;
        int                   ia;
        int                   ib;
        logic                 en;
        logic                 cj;
        logic [CW-1:0]        ia_i;
        logic [CW-1:0]        ib_i;
        logic signed [DW-1:0] a_re_d;
        logic signed [DW-1:0] a_im_d;
        logic signed [DW-1:0] b_re_d;
        logic signed [DW-1:0] b_im_d;
        logic signed [OW-1:0] ar;
        logic signed [OW-1:0] ai;
        logic signed [OW-1:0] br;
        logic signed [OW-1:0] bi;
        logic [2*OW-1:0]      prod;
        w_acc_re = '0;
        w_acc_im = '0;
        s        = int'(w_sel);
        for (int k = 0; k < N; k++) begin
            ia = k;
            ib = k;
            en = 1'b0;
            cj = 1'b0;
            case (r_mode)
                2'd0: begin
                    ib = s - k;
                    en = (ib >= 0) && (ib < N);
                end
                2'd1: begin
                    en = 1'b1;
                    cj = 1'b1;
                end
                2'd2: begin
                    ia = k + s - (N - 1);
                    en = (ia >= 0) && (ia < N);
                    cj = 1'b1;
                end
                2'd3: begin
                    en = (k == s);
                end
                default: begin
                    en = 1'b0;
                end
            endcase
            if (!en) begin
                ia = 0;
                ib = 0;
            end else begin
                ia = ia;
                ib = ib;
            end
            ia_i = CW'(ia);
            ib_i = CW'(ib);
            if ((r_state == S_LOAD) && (ia == N - 1)) begin
                a_re_d = in_a[2*DW-1:DW];
                a_im_d = in_a[DW-1:0];
            end else begin
                a_re_d = r_a_re[ia_i];
                a_im_d = r_a_im[ia_i];
            end
            if ((r_state == S_LOAD) && (ib == N - 1)) begin
                b_re_d = in_b[2*DW-1:DW];
                b_im_d = in_b[DW-1:0];
            end else begin
                b_re_d = r_b_re[ib_i];
                b_im_d = r_b_im[ib_i];
            end
            ar = {{(OW-DW){a_re_d[DW-1]}}, a_re_d};
            ai = {{(OW-DW){a_im_d[DW-1]}}, a_im_d};
            br = {{(OW-DW){b_re_d[DW-1]}}, b_re_d};
            bi = {{(OW-DW){b_im_d[DW-1]}}, b_im_d};
            if (cj) begin
                bi = -bi;
            end else begin
                bi = bi;
            end
            prod = cmul(ar, ai, br, bi);
            if (en) begin
                w_acc_re = w_acc_re + prod[2*OW-1:OW];
                w_acc_im = w_acc_im + prod[OW-1:0];
            end else begin
                w_acc_re = w_acc_re;
                w_acc_im = w_acc_im;
            end
        end
    end

    // Next-state, buffer write control and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_mode_nxt      = r_mode;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_cnt;
        w_out_valid_nxt = 1'b0;
        w_out_nxt       = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_mode_nxt  = in_mode;
                    w_cnt_nxt   = CW'(1);
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!in_valid) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(N - 1)) begin
                    w_wr_en         = 1'b1;
                    w_cnt_nxt       = '0;
                    w_idx_nxt       = XW'(1);
                    w_out_valid_nxt = 1'b1;
                    w_out_nxt       = {w_acc_re, w_acc_im};
                    w_state_nxt     = S_OUT;
                end else begin
                    w_wr_en   = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_OUT: begin
                if (r_idx < w_nres) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_nxt       = {w_acc_re, w_acc_im};
                    w_idx_nxt       = r_idx + XW'(1);
                end else begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_mode      <= 2'd0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_mode      <= w_mode_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out       <= w_out_nxt;
        end
    end

    // Sample buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_a_re[k] <= '0;
                r_a_im[k] <= '0;
                r_b_re[k] <= '0;
                r_b_im[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_a_re[w_wr_idx] <= in_a[2*DW-1:DW];
            r_a_im[w_wr_idx] <= in_a[DW-1:0];
            r_b_re[w_wr_idx] <= in_b[2*DW-1:DW];
            r_b_im[w_wr_idx] <= in_b[DW-1:0];
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule

// File: tb/tb_convcor_param.sv
// Directed, table-driven bench for convcor_param at default parameters.
module tb_convcor_param;
    localparam int DW = 8;
    localparam int N  = 3;
    localparam int OW = 19;

    typedef struct packed {
        logic [1:0]            mode;
        logic [2:0][7:0]       a_re;
        logic [2:0][7:0]       a_im;
        logic [2:0][7:0]       b_re;
        logic [2:0][7:0]       b_im;
        logic [3:0]            nres;
        logic [4:0][OW-1:0]    e_re;
        logic [4:0][OW-1:0]    e_im;
    } vec_t;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic [2*DW-1:0]   in_a     = '0;
    logic [2*DW-1:0]   in_b     = '0;
    logic [1:0]        in_mode  = 2'd0;
    logic              out_valid;
    logic [2*OW-1:0]   out;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl [5];

    always #5 clk = ~clk;

    convcor_param #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out       (out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_sample(input vec_t v, input int i);
        in_valid = 1'b1;
        in_a     = {v.a_re[i], v.a_im[i]};
        in_b     = {v.b_re[i], v.b_im[i]};
        in_mode  = (i == 0) ? v.mode : ~v.mode;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check({tag, "_load_valid"}, 64'(out_valid), 64'd0);
            check({tag, "_load_out"}, 64'(out), 64'd0);
            drive_sample(v, i);
        end
        for (int r = 0; r < int'(v.nres); r++) begin
            @(negedge clk);
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_res"}, 64'(out), 64'({v.e_re[r], v.e_im[r]}));
            in_valid = (r == 0) ? 1'b1 : 1'b0;
            in_a     = 16'hA5A5;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_drop_out"}, 64'(out), 64'd0);
    endtask

    initial begin
        logic seen;
        for (int t = 0; t < 4; t++) begin
            tbl[t].a_re = {8'sd0, 8'sd3, 8'sd1};
            tbl[t].a_im = {-8'sd1, 8'sd0, 8'sd2};
            tbl[t].b_re = {8'sd2, 8'sd1, 8'sd1};
            tbl[t].b_im = {8'sd0, 8'sd1, 8'sd0};
        end
        tbl[0].mode = 2'd0;
        tbl[0].nres = 4'd5;
        tbl[0].e_re = {19'sd0, 19'sd7, 19'sd5, 19'sd2, 19'sd1};
        tbl[0].e_im = {-19'sd2, -19'sd1, 19'sd6, 19'sd3, 19'sd2};
        tbl[1].mode = 2'd1;
        tbl[1].nres = 4'd1;
        tbl[1].e_re = {19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd4};
        tbl[1].e_im = {19'sd0, 19'sd0, 19'sd0, 19'sd0, -19'sd3};
        tbl[2].mode = 2'd2;
        tbl[2].nres = 4'd5;
        tbl[2].e_re = {19'sd0, 19'sd2, 19'sd4, 19'sd9, 19'sd2};
        tbl[2].e_im = {-19'sd1, -19'sd1, -19'sd3, 19'sd1, 19'sd4};
        tbl[3].mode = 2'd3;
        tbl[3].nres = 4'd3;
        tbl[3].e_re = {19'sd0, 19'sd0, 19'sd0, 19'sd3, 19'sd1};
        tbl[3].e_im = {19'sd0, 19'sd0, -19'sd2, 19'sd3, 19'sd2};
        tbl[4].mode = 2'd0;
        tbl[4].nres = 4'd5;
        tbl[4].a_re = {8'h80, 8'h80, 8'h80};
        tbl[4].a_im = {8'h80, 8'h80, 8'h80};
        tbl[4].b_re = {8'h80, 8'h80, 8'h80};
        tbl[4].b_im = {8'h80, 8'h80, 8'h80};
        tbl[4].e_re = {19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
        tbl[4].e_im = {19'sd32768, 19'sd65536, 19'sd98304, 19'sd65536, 19'sd32768};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out), 64'd0);

        for (int t = 0; t < 5; t++) begin
            run_job(tbl[t], $sformatf("vec%0d", t));
        end

        // Aborted job: two samples then in_valid drops.
        @(negedge clk);
        drive_sample(tbl[0], 0);
        @(negedge clk);
        drive_sample(tbl[0], 1);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        run_job(tbl[0], "after_abort");

        // Reset asserted while the third mode-0 result is on the output.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            drive_sample(tbl[0], i);
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("pre_rst_valid", 64'(out_valid), 64'd1);
            check("pre_rst_res", 64'(out), 64'({tbl[0].e_re[r], tbl[0].e_im[r]}));
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(tbl[1], "after_rst");
        run_job(tbl[2], "after_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
